// File: rtl/vigna_bus_pkg.sv
// rtl/vigna_bus_pkg.sv - shared encodings and constants for the vigna bus arbiter
package vigna_bus_pkg;

  // Arbiter FSM states: idle, or owned by the instruction or data port
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_t;

  // Which port held the most recent grant (drives round-robin)
  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } arb_grant_t;

  // RV32 "addi x0, x0, 0": an aborted fetch decodes to a harmless NOP
  localparam logic [31:0] NOP_INSN = 32'h00000013;

endpackage

// File: rtl/vigna_arb_watchdog.sv
// rtl/vigna_arb_watchdog.sv - busy-cycle timer that flags a hung memory transaction
module vigna_arb_watchdog #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic active,
  input  logic m_ready,
  output logic expire
);

  // The timer is 16 bits wide, so larger limits could never be reached
  generate
    if (TIMEOUT > 65535) begin : g_timeout_range
      $error("vigna_arb_watchdog: TIMEOUT must not exceed 65535");
    end
  endgenerate

  localparam int unsigned LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [15:0] LAST = 16'(LAST_I);

  logic [15:0] timer;

  // Count busy cycles without a target response; cleared on every new grant
  always_ff @(posedge clk) begin
    if (!resetn) begin
      timer <= 16'd0;
    end else if (start) begin
      timer <= 16'd0;
    end else if (active && !m_ready) begin
      timer <= timer + 16'd1;
    end
  end

  // Fires in the last allowed busy cycle; a real m_ready in that cycle wins
  always_comb begin
    expire = (TIMEOUT != 0) && active && !m_ready && (timer == LAST);
  end

endmodule

// File: rtl/vigna_mem_arbiter.sv
// rtl/vigna_mem_arbiter.sv - merges vigna instruction and data ports onto one memory port
module vigna_mem_arbiter
  import vigna_bus_pkg::*;
#(
  parameter bit          DATA_FIRST = 1'b1,
  parameter int unsigned TIMEOUT    = 0,
  parameter logic [31:0] ERR_RDATA  = NOP_INSN
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  output logic [31:0] d_rdata,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  input  logic [31:0] m_rdata,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        bus_err
);

  arb_state_t  state;
  arb_state_t  state_nxt;
  arb_grant_t  last_grant;
  logic        pick_d;
  logic        grant_go;
  logic        busy;
  logic        expire;
  logic        done;
  logic [31:0] resp_data;

  // Winner selection: data first when configured, otherwise the port that lost last time
  always_comb begin
    pick_d   = d_valid && (!i_valid || DATA_FIRST || (last_grant == GRANT_I));
    grant_go = (state == ARB_IDLE) && (i_valid || d_valid);
    busy     = (state != ARB_IDLE);
    done     = busy && (m_ready || expire);
  end

  vigna_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .resetn  (resetn),
    .start   (grant_go),
    .active  (busy),
    .m_ready (m_ready),
    .expire  (expire)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: IDLE always lasts one cycle so a finished master has dropped valid
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (i_valid || d_valid) begin
          state_nxt = pick_d ? ARB_BUSY_D : ARB_BUSY_I;
        end
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        if (m_ready || expire) begin
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Completion is routed only to the owner; everyone else sees ready=0 and rdata=0
  always_comb begin
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    i_rdata   = 32'd0;
    d_rdata   = 32'd0;
    resp_data = m_ready ? m_rdata : ERR_RDATA;
    if ((state == ARB_BUSY_I) && done) begin
      i_ready = 1'b1;
      i_rdata = resp_data;
    end
    if ((state == ARB_BUSY_D) && done) begin
      d_ready = 1'b1;
      d_rdata = resp_data;
    end
  end

  // Shared-port request registers: loaded at grant, retired on completion or abort
  always_ff @(posedge clk) begin
    if (!resetn) begin
      m_valid    <= 1'b0;
      m_addr     <= 32'd0;
      m_wdata    <= 32'd0;
      m_wstrb    <= 4'd0;
      bus_err    <= 1'b0;
      last_grant <= GRANT_D;
    end else begin
      bus_err <= 1'b0;
      if (grant_go) begin
        m_valid    <= 1'b1;
        m_addr     <= pick_d ? d_addr : i_addr;
        m_wdata    <= pick_d ? d_wdata : 32'd0;
        m_wstrb    <= pick_d ? d_wstrb : 4'd0;
        last_grant <= pick_d ? GRANT_D : GRANT_I;
      end else if (done) begin
        m_valid <= 1'b0;
        m_wstrb <= 4'd0;
        bus_err <= !m_ready;
      end
    end
  end

endmodule
